// File: rtl/fsm_3l_anpc.sv
// fsm_3l_anpc: gate sequencer for one 3L-ANPC leg with timed break-before-make steps.
// Optional debug outputs (state, transition, finish_transition, counter) are
// enabled by defining FSM_3L_ANPC_DEBUG_EN.

package PKG_fsm_3lanpc;
  typedef enum logic [1:0] {
    type_I   = 2'd0,
    type_II  = 2'd1,
    type_III = 2'd2
  } _commtypes_t;
endpackage

module fsm_3l_anpc
  import PKG_fsm_3lanpc::*;
#(
  parameter int unsigned TDELAY_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TDELAY_WIDTH-1:0] t_short,
  input  logic [TDELAY_WIDTH-1:0] t_off_on,
  input  logic [TDELAY_WIDTH-1:0] t_on_offV0,
  input  logic [TDELAY_WIDTH-1:0] t_offV0_on,
  input  logic [TDELAY_WIDTH-1:0] t_off_onI0,
  input  logic [1:0]              v_lev,
  input  _commtypes_t             comm_type,
  output logic [5:0]              S_out
`ifdef FSM_3L_ANPC_DEBUG_EN
  ,
  output logic [2:0]              state,
  output logic                    transition,
  output logic                    finish_transition,
  output logic [TDELAY_WIDTH-1:0] counter
`endif
);

  localparam int unsigned W = TDELAY_WIDTH;

  localparam logic [5:0] V_P  = 6'b100011;
  localparam logic [5:0] V_N  = 6'b011100;
  localparam logic [5:0] V_0U = 6'b010010;
  localparam logic [5:0] V_0L = 6'b100100;
  localparam logic [5:0] V_0F = 6'b110110;
  localparam logic [5:0] V_MID = 6'b000110;

  localparam logic [1:0] C_ZERO = 2'b00;
  localparam logic [1:0] C_P    = 2'b01;
  localparam logic [1:0] C_N    = 2'b10;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    STABLE = 3'd1,
    STEP1  = 3'd2,
    STEP2  = 3'd3
  } state_t;

  state_t       st_q, st_d;
  logic [5:0]   out_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] dly_q, dly_d;
  _commtypes_t  typ_q, typ_d;
  logic [5:0]   hdst_q, hdst_d;
  logic [5:0]   fin_q, fin_d;
  logic         pend_q, pend_d;
  logic         zhold_q, zhold_d;
  logic         lastp_q, lastp_d;
  logic [1:0]   lev_q;
  _commtypes_t  comm_q;

  logic [1:0]   cur_cls, req_cls;
  logic         lp_eff;
  logic [W-1:0] dly_eff, init_eff;
  logic         step_done, fin_half;
  logic [5:0]   hd;

  // Level class of a gate vector: P, N, or any zero vector
  function automatic logic [1:0] vec_cls(input logic [5:0] v);
    if (v == V_P)      return C_P;
    else if (v == V_N) return C_N;
    else               return C_ZERO;
  endfunction

  // Destination vector for a requested class under a commutation type
  function automatic logic [5:0] dst_vec(input logic [1:0] c, input _commtypes_t t,
                                         input logic lp);
    case (c)
      C_P:     return V_P;
      C_N:     return V_N;
      default: return (t == type_I) ? (lp ? V_0U : V_0L) : V_0F;
    endcase
  endfunction

  // First-step delay for a half-transition towards vector d
  function automatic logic [W-1:0] step1_dly(input _commtypes_t t, input logic [5:0] d);
    case (t)
      type_I:  return t_off_on;
      type_II: return (vec_cls(d) == C_ZERO) ? t_on_offV0 : t_offV0_on;
      default: return t_off_onI0;
    endcase
  endfunction

  assign cur_cls   = vec_cls(S_out);
  assign req_cls   = (lev_q == C_P || lev_q == C_N) ? lev_q : C_ZERO;
  assign lp_eff    = (cur_cls == C_P) ? 1'b1 : (cur_cls == C_N) ? 1'b0 : lastp_q;
  assign dly_eff   = (dly_q == '0) ? W'(1) : dly_q;
  assign init_eff  = (t_off_on == '0) ? W'(1) : t_off_on;
  assign step_done = (cnt_q >= dly_eff);

  // Next-state and next-output logic
  always_comb begin
    st_d     = st_q;
    out_d    = S_out;
    cnt_d    = cnt_q;
    dly_d    = dly_q;
    typ_d    = typ_q;
    hdst_d   = hdst_q;
    fin_d    = fin_q;
    pend_d   = pend_q;
    zhold_d  = zhold_q;
    lastp_d  = lastp_q;
    fin_half = 1'b0;
    hd       = hdst_q;

    case (st_q)
      INIT: begin
        if (cnt_q >= init_eff) begin
          out_d = dst_vec(req_cls, comm_q, lastp_q);
          st_d  = STABLE;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      STABLE: begin
        lastp_d = lp_eff;
        if (req_cls != cur_cls) begin
          typ_d = comm_q;
          if (cur_cls != C_ZERO && req_cls != C_ZERO) begin
            // Direct P<->N: go through zero first, finish later
            hd     = dst_vec(C_ZERO, comm_q, cur_cls == C_P);
            pend_d = 1'b1;
            fin_d  = dst_vec(req_cls, comm_q, lp_eff);
          end else begin
            hd     = dst_vec(req_cls, comm_q, lp_eff);
            pend_d = 1'b0;
          end
          hdst_d = hd;
          out_d  = S_out & hd;
          dly_d  = step1_dly(comm_q, hd);
          cnt_d  = W'(1);
          st_d   = STEP1;
        end
      end
      STEP1: begin
        if (step_done) begin
          if (typ_q == type_III) begin
            out_d = S_out | (hdst_q & V_MID);
            dly_d = t_short;
            cnt_d = W'(1);
            st_d  = STEP2;
          end else begin
            fin_half = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      STEP2: begin
        if (step_done) begin
          if (zhold_q) begin
            // Zero hold done: start the zero->final half
            zhold_d = 1'b0;
            hdst_d  = fin_q;
            out_d   = S_out & fin_q;
            dly_d   = step1_dly(typ_q, fin_q);
            cnt_d   = W'(1);
            st_d    = STEP1;
          end else begin
            fin_half = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      default: st_d = INIT;
    endcase

    if (fin_half) begin
      out_d = hdst_q;
      if (pend_q) begin
        pend_d  = 1'b0;
        zhold_d = 1'b1;
        dly_d   = t_short;
        cnt_d   = W'(1);
        st_d    = STEP2;
      end else begin
        st_d = STABLE;
      end
    end
  end

  // State, datapath and request-sampling registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= INIT;
      S_out   <= 6'b000000;
      cnt_q   <= W'(1);
      dly_q   <= '0;
      typ_q   <= type_I;
      hdst_q  <= 6'b000000;
      fin_q   <= 6'b000000;
      pend_q  <= 1'b0;
      zhold_q <= 1'b0;
      lastp_q <= 1'b1;
      lev_q   <= 2'b00;
      comm_q  <= type_I;
    end else begin
      st_q    <= st_d;
      S_out   <= out_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      typ_q   <= typ_d;
      hdst_q  <= hdst_d;
      fin_q   <= fin_d;
      pend_q  <= pend_d;
      zhold_q <= zhold_d;
      lastp_q <= lastp_d;
      lev_q   <= v_lev;
      comm_q  <= comm_type;
    end
  end

`ifdef FSM_3L_ANPC_DEBUG_EN
  // Debug status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      transition        <= 1'b0;
      finish_transition <= 1'b0;
    end else begin
      transition        <= (st_d == STEP1) || (st_d == STEP2);
      finish_transition <= ((st_q == STEP1) || (st_q == STEP2)) && (st_d == STABLE);
    end
  end

  assign state   = st_q;
  assign counter = cnt_q;
`endif

endmodule

// File: tb/tb_fsm_3l_anpc.sv
// tb_fsm_3l_anpc: scoreboard bench with a sequence-level reference model of fsm_3l_anpc.
module tb_fsm_3l_anpc;
  import PKG_fsm_3lanpc::*;

  localparam int unsigned W = 16;

  localparam logic [5:0] V_P  = 6'b100011;
  localparam logic [5:0] V_N  = 6'b011100;
  localparam logic [5:0] V_0U = 6'b010010;
  localparam logic [5:0] V_0L = 6'b100100;
  localparam logic [5:0] V_0F = 6'b110110;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] t_short, t_off_on, t_on_offV0, t_offV0_on, t_off_onI0;
  logic [1:0]   v_lev = 2'b00;
  _commtypes_t  comm_type = type_I;
  logic [5:0]   S_out;
`ifdef FSM_3L_ANPC_DEBUG_EN
  logic [2:0]   dbg_state;
  logic         dbg_transition, dbg_finish;
  logic [W-1:0] dbg_counter;
`endif

  int n_vec = 0;
  int n_err = 0;

  fsm_3l_anpc #(.TDELAY_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .t_short    (t_short),
    .t_off_on   (t_off_on),
    .t_on_offV0 (t_on_offV0),
    .t_offV0_on (t_offV0_on),
    .t_off_onI0 (t_off_onI0),
    .v_lev      (v_lev),
    .comm_type  (comm_type),
    .S_out      (S_out)
`ifdef FSM_3L_ANPC_DEBUG_EN
    ,
    .state             (dbg_state),
    .transition        (dbg_transition),
    .finish_transition (dbg_finish),
    .counter           (dbg_counter)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [5:0]  exp_q[$];
  logic [5:0]  plan[$];
  logic [5:0]  m_out;
  logic        m_init;
  int          init_left;
  logic        m_lastp;
  logic [1:0]  m_vq;
  _commtypes_t m_cq;

  function automatic int eff(input logic [W-1:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  // 0 = zero, 1 = P, 2 = N
  function automatic int lvl_of_req(input logic [1:0] l);
    return (l == 2'b01) ? 1 : (l == 2'b10) ? 2 : 0;
  endfunction

  function automatic int lvl_of_vec(input logic [5:0] v);
    return (v == V_P) ? 1 : (v == V_N) ? 2 : 0;
  endfunction

  function automatic logic [5:0] target(input int lvl, input _commtypes_t t, input logic lastp);
    if (lvl == 1) return V_P;
    if (lvl == 2) return V_N;
    if (t == type_I) return lastp ? V_0U : V_0L;
    return V_0F;
  endfunction

  task automatic hold(input logic [5:0] v, input int cycles);
    for (int i = 0; i < cycles; i++) plan.push_back(v);
  endtask

  // Intermediate vectors for one src->dst move (final vector not included)
  task automatic plan_half(input logic [5:0] src, input logic [5:0] dst, input _commtypes_t t);
    int d1;
    if (t == type_I)       d1 = eff(t_off_on);
    else if (t == type_II) d1 = (lvl_of_vec(dst) == 0) ? eff(t_on_offV0) : eff(t_offV0_on);
    else                   d1 = eff(t_off_onI0);
    hold(src & dst, d1);
    if (t == type_III) hold((src & dst) | (dst & 6'b000110), eff(t_short));
  endtask

  function automatic _commtypes_t to_typ(input int unsigned k);
    case (k)
      0:       return type_I;
      1:       return type_II;
      default: return type_III;
    endcase
  endfunction

  // One model step per rising edge; pushes the expected post-edge S_out
  always @(posedge clk) begin
    if (!rst) begin
      m_out = 6'b0;
      plan.delete();
      m_init = 1'b1;
      init_left = eff(t_off_on);
      m_lastp = 1'b1;
      m_vq = 2'b00;
      m_cq = type_I;
    end else begin
      if (m_init) begin
        init_left--;
        if (init_left == 0) begin
          m_out  = target(lvl_of_req(m_vq), m_cq, m_lastp);
          m_init = 1'b0;
        end
      end else if (plan.size() > 0) begin
        m_out = plan.pop_front();
      end else if (lvl_of_req(m_vq) != lvl_of_vec(m_out)) begin
        logic [5:0] fin, z;
        fin = target(lvl_of_req(m_vq), m_cq, m_lastp);
        if (lvl_of_vec(m_out) != 0 && lvl_of_req(m_vq) != 0) begin
          z = target(0, m_cq, lvl_of_vec(m_out) == 1);
          plan_half(m_out, z, m_cq);
          hold(z, eff(t_short));
          plan_half(z, fin, m_cq);
        end else begin
          plan_half(m_out, fin, m_cq);
        end
        plan.push_back(fin);
        m_out = plan.pop_front();
      end
      if (m_out == V_P) m_lastp = 1'b1;
      if (m_out == V_N) m_lastp = 1'b0;
      m_vq = v_lev;
      m_cq = comm_type;
    end
    exp_q.push_back(m_out);
  end

  // Monitor: compare one expected vector per cycle, away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [5:0] e;
      e = exp_q.pop_front();
      n_vec++;
      if (S_out !== e) begin
        n_err++;
        $display("FAIL s_out t=%0t got %b want %b", $time, S_out, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_delays(input int ts, input int too, input int ton0, input int t0on,
                            input int ti0);
    t_short    = 16'(ts);
    t_off_on   = 16'(too);
    t_on_offV0 = 16'(ton0);
    t_offV0_on = 16'(t0on);
    t_off_onI0 = 16'(ti0);
  endtask

  task automatic do_reset(input int ts, input int too, input int ton0, input int t0on,
                          input int ti0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if (S_out !== 6'b000000) begin
      n_err++;
      $display("FAIL async_reset got %b want 000000", S_out);
    end
    set_delays(ts, too, ton0, t0on, ti0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drive(input logic [1:0] l, input _commtypes_t t, input int cycles);
    @(negedge clk);
    v_lev = l;
    comm_type = t;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic check_now(input string name, input logic [5:0] want);
    #2;
    n_vec++;
    if (S_out !== want) begin
      n_err++;
      $display("FAIL %s got %b want %b", name, S_out, want);
    end
  endtask

  initial begin
    set_delays(3, 10, 7, 6, 9);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    // Directed sequence with the reference delays
    drive(2'b00, type_I, 14);
    check_now("init_to_0U", V_0U);
    drive(2'b01, type_I, 4);
    drive(2'b00, type_I, 3);
    drive(2'b01, type_I, 30);
    drive(2'b00, type_I, 30);
    drive(2'b01, type_II, 30);
    drive(2'b00, type_II, 20);
    drive(2'b01, type_II, 20);
    drive(2'b00, type_III, 25);
    check_now("typeIII_to_0F", V_0F);
    drive(2'b10, type_I, 25);
    check_now("0F_to_N", V_N);
    drive(2'b10, type_II, 5);
    drive(2'b10, type_III, 5);
    check_now("comm_change_only", V_N);
    drive(2'b01, type_III, 45);
    drive(2'b10, type_I, 60);
    drive(2'b11, type_I, 30);
    check_now("lev11_zero_from_N", V_0L);
    drive(2'b01, type_II, 4);
    do_reset(3, 10, 7, 6, 9);
    drive(2'b00, type_I, 20);

    // Randomized segments, small delays including zero
    for (int seg = 0; seg < 6; seg++) begin
      do_reset($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 5),
               $urandom_range(0, 5), $urandom_range(0, 5));
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(0, 29) == 0)
          do_reset(int'(t_short), int'(t_off_on), int'(t_on_offV0),
                   int'(t_offV0_on), int'(t_off_onI0));
        drive(2'($urandom_range(0, 3)), to_typ($urandom_range(0, 2)),
              $urandom_range(1, 25));
      end
    end

    drive(v_lev, comm_type, 40);
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
